branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit_pkg.sv | 32 +++
 rtl/branch_predict_unit_pred_fifo.sv | 63 ++++++
 rtl/branch_predict_unit.sv | 120 ++++++++++++
 tb/tb_branch_predict_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Shared constants and helpers for the branch predictor.
// Counter encodings, branch opcode and the resolve bundle.
package branch_predict_unit_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        taken;
  } resolve_t;

  function automatic logic [1:0] ctr_next(
    input logic [1:0] c,
    input logic       t
  );
    logic [1:0] n;
    n = c;
    unique case (1'b1)
      t && (c != CTR_ST):   n = c + 2'd1;
      !t && (c != CTR_SNT): n = c - 2'd1;
      default:              n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_predict_unit_pred_fifo.sv
// In-flight prediction queue: 1-bit entries, flush clears everything.
// Push and pop together stay legal when full.
module pred_fifo
  import branch_predict_unit_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic          din,
  output logic          dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          overflow
);

  logic [QDEPTH-1:0] mem;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              rd_en;
  logic              wr_en;

  assign full  = (count == CW'(QDEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  assign rd_en    = pop & ~empty;
  assign wr_en    = push & (~full | rd_en);
  assign overflow = push & full & ~rd_en & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal 2-bit branch predictor with in-flight prediction queue.
// Define BPU_STATS_EN to add branch/mispredict counters.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int QDEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset_in,
  input  logic [31:0] pc_in,
  input  logic [6:0]  instr_opcode_in,
  input  logic        stall_in,
  input  logic        resolve_valid_in,
  input  logic [31:0] resolve_pc_in,
  input  logic        resolve_taken_in,
  output logic        branch_taken_out,
  output logic        wrong_predict_out,
  output logic [3:0]  queue_count_out,
  output logic        error_out
`ifdef BPU_STATS_EN
  ,
  output logic [31:0] branch_count_out,
  output logic [31:0] mispredict_count_out
`endif
);

  localparam int IW = $clog2(BHT_ENTRIES);
  localparam int CW = $clog2(QDEPTH) + 1;

  logic [1:0]    bht [BHT_ENTRIES];
  logic [IW-1:0] lidx;
  logic [IW-1:0] uidx;
  resolve_t      rsv;

  logic          is_branch;
  logic          pred;
  logic          push;
  logic          pop;
  logic          mispredict;
  logic          q_head;
  logic [CW-1:0] q_count;
  logic          q_full;
  logic          q_empty;
  logic          q_overflow;
  logic          unused;

  assign rsv = '{valid: resolve_valid_in,
                 pc:    resolve_pc_in,
                 taken: resolve_taken_in};

  assign lidx = pc_in[IW+1:2];
  assign uidx = rsv.pc[IW+1:2];

  assign unused = ^{pc_in[31:IW+2], pc_in[1:0],
                    resolve_pc_in[31:IW+2], resolve_pc_in[1:0],
                    q_full};

  assign is_branch = (instr_opcode_in == OPC_BRANCH);
  assign pred      = bht[lidx][1];
  assign push      = is_branch & ~stall_in;
  assign pop       = rsv.valid & ~q_empty;
  assign mispredict = pop & (q_head != rsv.taken);

  assign branch_taken_out  = reset_in & push & pred;
  assign wrong_predict_out = reset_in & mispredict;
  assign queue_count_out   = 4'(q_count);

  // A mispredict squashes the queue and any same-cycle push.
  pred_fifo #(
    .QDEPTH(QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_in),
    .push    (push & ~mispredict),
    .pop     (pop),
    .flush   (mispredict),
    .din     (pred),
    .dout    (q_head),
    .count   (q_count),
    .full    (q_full),
    .empty   (q_empty),
    .overflow(q_overflow)
  );

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= CTR_WNT;
      end
    end else if (pop) begin
      bht[uidx] <= ctr_next(bht[uidx], rsv.taken);
    end
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      error_out <= 1'b0;
    end else if ((rsv.valid & q_empty) | q_overflow) begin
      error_out <= 1'b1;
    end
  end

`ifdef BPU_STATS_EN
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      branch_count_out     <= '0;
      mispredict_count_out <= '0;
    end else begin
      if (pop && branch_count_out != '1) begin
        branch_count_out <= branch_count_out + 32'd1;
      end
      if (mispredict && mispredict_count_out != '1) begin
        mispredict_count_out <= mispredict_count_out + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit.
// Stats checks run only when BPU_STATS_EN is defined.
module tb_branch_predict_unit;
  import branch_predict_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_in;
  logic [31:0] pc_in;
  logic [6:0]  instr_opcode_in;
  logic        stall_in;
  logic        resolve_valid_in;
  logic [31:0] resolve_pc_in;
  logic        resolve_taken_in;
  logic        branch_taken_out;
  logic        wrong_predict_out;
  logic [3:0]  queue_count_out;
  logic        error_out;
`ifdef BPU_STATS_EN
  logic [31:0] branch_count_out;
  logic [31:0] mispredict_count_out;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk              (clk),
    .reset_in         (reset_in),
    .pc_in            (pc_in),
    .instr_opcode_in  (instr_opcode_in),
    .stall_in         (stall_in),
    .resolve_valid_in (resolve_valid_in),
    .resolve_pc_in    (resolve_pc_in),
    .resolve_taken_in (resolve_taken_in),
    .branch_taken_out (branch_taken_out),
    .wrong_predict_out(wrong_predict_out),
    .queue_count_out  (queue_count_out),
    .error_out        (error_out)
`ifdef BPU_STATS_EN
    ,
    .branch_count_out    (branch_count_out),
    .mispredict_count_out(mispredict_count_out)
`endif
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(
    input logic [31:0] p,
    input logic        br,
    input logic        st,
    input logic        rv,
    input logic [31:0] rp,
    input logic        rt
  );
    @(negedge clk);
    pc_in            = p;
    instr_opcode_in  = br ? OPC_BRANCH : 7'h13;
    stall_in         = st;
    resolve_valid_in = rv;
    resolve_pc_in    = rp;
    resolve_taken_in = rt;
    #1;
  endtask

  task automatic idle();
    drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_in         = 1'b0;
    instr_opcode_in  = 7'h13;
    resolve_valid_in = 1'b0;
    #1;
    @(negedge clk);
    reset_in = 1'b1;
  endtask

`ifdef BPU_STATS_EN
  logic tk [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
`endif

  initial begin
    reset_in         = 1'b0;
    pc_in            = 32'h40;
    instr_opcode_in  = OPC_BRANCH;
    stall_in         = 1'b0;
    resolve_valid_in = 1'b1;
    resolve_pc_in    = 32'h40;
    resolve_taken_in = 1'b1;
    #12;
    chk("rst_bt", branch_taken_out, 0);
    chk("rst_wp", wrong_predict_out, 0);
    chk("rst_cnt", queue_count_out, 0);
    chk("rst_err", error_out, 0);
    resolve_valid_in = 1'b0;
    instr_opcode_in  = 7'h13;
    @(negedge clk);
    reset_in = 1'b1;

    // counter 01 at 0x40 predicts not-taken
    drive(32'h40, 1, 0, 0, 0, 0);
    chk("s1_bt", branch_taken_out, 0);
    drive(32'h0, 0, 0, 1, 32'h40, 1);
    chk("s2_cnt", queue_count_out, 1);
    chk("s2_wp", wrong_predict_out, 1);
    drive(32'h40, 1, 0, 0, 0, 0);
    chk("s3_cnt", queue_count_out, 0);
    chk("s3_bt", branch_taken_out, 1);
    // lookup sees pre-update 10 while resolve writes 11
    drive(32'h40, 1, 0, 1, 32'h40, 1);
    chk("s4_wp", wrong_predict_out, 0);
    chk("s4_bt", branch_taken_out, 1);
    drive(32'h0, 0, 0, 1, 32'h40, 1);
    chk("s5_cnt", queue_count_out, 1);
    chk("s5_wp", wrong_predict_out, 0);
    drive(32'h40, 1, 1, 0, 0, 0);
    chk("s6_stall_bt", branch_taken_out, 0);
    drive(32'h40, 1, 0, 0, 0, 0);
    chk("s7_cnt", queue_count_out, 0);
    chk("s7_bt", branch_taken_out, 1);
    drive(32'h0, 0, 0, 1, 32'h40, 0);
    chk("s8_wp", wrong_predict_out, 1);
    drive(32'h40, 1, 0, 0, 0, 0);
    chk("s9_cnt", queue_count_out, 0);
    chk("s9_sat_bt", branch_taken_out, 1);
    drive(32'h80, 1, 0, 0, 0, 0);
    chk("s10_bt", branch_taken_out, 0);
    drive(32'h40, 1, 0, 1, 32'h40, 1);
    chk("s11_wp", wrong_predict_out, 0);
    chk("s11_cnt", queue_count_out, 2);
    drive(32'h80, 1, 0, 1, 32'h80, 1);
    chk("s12_wp", wrong_predict_out, 1);
    chk("s12_bt", branch_taken_out, 0);
    idle();
    chk("s13_flush_cnt", queue_count_out, 0);
    chk("s13_err", error_out, 0);

    // resolve against an empty queue
    drive(32'h0, 0, 0, 1, 32'h80, 0);
    chk("s14_wp", wrong_predict_out, 0);
    drive(32'h80, 1, 0, 0, 0, 0);
    chk("s15_err", error_out, 1);
    chk("s15_noupd_bt", branch_taken_out, 1);

    // async reset with an entry pending
    @(negedge clk);
    reset_in = 1'b0;
    #1;
    chk("r2_cnt", queue_count_out, 0);
    chk("r2_err", error_out, 0);
    chk("r2_bt", branch_taken_out, 0);
    instr_opcode_in = 7'h13;
    @(negedge clk);
    reset_in = 1'b1;

    drive(32'h40, 1, 0, 0, 0, 0);
    chk("r3_bt", branch_taken_out, 0);
    for (int i = 1; i < 5; i++) begin
      drive(32'h40 + 32'(4 * i), 1, 0, 0, 0, 0);
      if (i == 4) begin
        chk("full_cnt", queue_count_out, 4);
        chk("full_err", error_out, 0);
      end
    end
    idle();
    chk("ovf_cnt", queue_count_out, 4);
    chk("ovf_err", error_out, 1);
    drive(32'h54, 1, 0, 1, 32'h40, 0);
    chk("pp_wp", wrong_predict_out, 0);
    for (int i = 0; i < 4; i++) begin
      drive(32'h0, 0, 0, 1, 32'h44 + 32'(4 * i), 0);
      chk("drain_cnt", queue_count_out, 32'(4 - i));
      chk("drain_wp", wrong_predict_out, 0);
    end
    idle();
    chk("drain_end_cnt", queue_count_out, 0);
    chk("err_sticky", error_out, 1);

`ifdef BPU_STATS_EN
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      drive(32'h200, 1, 0, 0, 0, 0);
      drive(32'h0, 0, 0, 1, 32'h200, tk[i]);
    end
    idle();
    chk("st_branches", branch_count_out, 10);
    chk("st_mispred", mispredict_count_out, 3);
    drive(32'h200, 1, 0, 0, 0, 0);
    @(negedge clk);
    reset_in = 1'b0;
    #1;
    chk("st_rst_br", branch_count_out, 0);
    chk("st_rst_mp", mispredict_count_out, 0);
    @(negedge clk);
    reset_in = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
